// File: rtl/dma_bus_master.sv
// Single-channel 68030-bus DMA initiator: arbitrates for the CPU bus, then copies
// 16-bit words from a source to a destination address, one word buffered between them.
module dma_bus_master #(
  parameter int TIMEOUT   = 64,
  parameter int MAX_BURST = 16
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        n_br,
  input  logic        n_bg,
  output logic        n_bgack,
  input  logic        n_as_in,
  input  logic        n_bgack_in,
  output logic        bus_oe,
  output logic [31:0] addr_out,
  output logic        n_as_out,
  output logic        n_ds_out,
  output logic        rn_w_out,
  output logic [1:0]  siz_out,
  output logic [2:0]  fc_out,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_oe,
  input  logic [1:0]  n_dsack,
  input  logic        n_berr
);

  typedef enum logic [3:0] {
    IDLE, REQ, OWN, RD, RD_END, WR_ADDR, WR, WR_END, REL
  } state_t;

  state_t      state_q, next_state;
  logic [31:0] src_q, dst_q;
  logic [15:0] cnt_q;
  logic [15:0] burst_q;
  logic [7:0]  tmo_q;
  logic [15:0] word_q;
  logic        busy_q, done_q, err_q;
  logic        abort_q;   // current tenure ends because the transfer was abandoned
  logic        final_q;   // the REL being entered ends the whole transfer

  logic accept, zero_start, capture, abort, advance, rel_final;
  logic tmo_expired, bus_fault, enter_rel;

  assign tmo_expired = (tmo_q == 8'(TIMEOUT - 1));
  // Bus error wins over a simultaneous DSACK; a byte-port DSACK cannot be sized.
  assign bus_fault   = !n_berr || (n_dsack == 2'b10) ||
                       ((n_dsack == 2'b11) && tmo_expired);
  assign enter_rel   = (state_q != REL) && (next_state == REL);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state_q;
    accept     = 1'b0;
    zero_start = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    advance    = 1'b0;
    rel_final  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != 16'd0) begin
            accept     = 1'b1;
            next_state = REQ;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      REQ: begin
        if (!n_bg && n_as_in && n_bgack_in) next_state = OWN;
      end
      OWN: next_state = RD;
      RD: begin
        if (bus_fault) begin
          abort      = 1'b1;
          next_state = RD_END;
        end else if (n_dsack != 2'b11) begin
          capture    = 1'b1;
          next_state = RD_END;
        end
      end
      RD_END: begin
        rel_final  = abort_q;
        next_state = abort_q ? REL : WR_ADDR;
      end
      WR_ADDR: next_state = WR;
      WR: begin
        if (bus_fault) begin
          abort      = 1'b1;
          next_state = WR_END;
        end else if (n_dsack != 2'b11) begin
          next_state = WR_END;
        end
      end
      WR_END: begin
        if (abort_q) begin
          rel_final  = 1'b1;
          next_state = REL;
        end else begin
          advance = 1'b1;
          if (cnt_q == 16'd1) begin
            rel_final  = 1'b1;
            next_state = REL;
          end else if (burst_q + 16'd1 == MAX_BURST[15:0]) begin
            next_state = REL;
          end else begin
            next_state = RD;
          end
        end
      end
      REL:     next_state = final_q ? IDLE : REQ;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      tmo_q   <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      final_q <= 1'b0;
    end else begin
      state_q <= next_state;
      done_q  <= zero_start || (enter_rel && rel_final);

      if (accept) begin
        src_q   <= src_addr & 32'hFFFF_FFFE;
        dst_q   <= dst_addr & 32'hFFFF_FFFE;
        cnt_q   <= count;
        busy_q  <= 1'b1;
        err_q   <= 1'b0;
        abort_q <= 1'b0;
      end

      if (enter_rel) final_q <= rel_final;
      if (enter_rel && rel_final) busy_q <= 1'b0;

      // Restarts on every strobe assertion: counts only while sitting in RD or WR.
      if (state_q == RD || state_q == WR) tmo_q <= tmo_q + 8'd1;
      else                                tmo_q <= '0;

      if (capture) begin
        word_q <= ((n_dsack == 2'b00) && src_q[1]) ? data_in[15:0] : data_in[31:16];
      end

      if (abort) begin
        err_q   <= 1'b1;
        abort_q <= 1'b1;
      end

      if (state_q == OWN) begin
        burst_q <= '0;
      end else if (advance) begin
        burst_q <= burst_q + 16'd1;
      end

      if (advance) begin
        src_q <= src_q + 32'd2;
        dst_q <= dst_q + 32'd2;
        cnt_q <= cnt_q - 16'd1;
      end
    end
  end

  // Bus controls decode straight from the state register, so an asynchronous
  // reset releases the bus without waiting for a clock.
  assign n_br     = (state_q != REQ);
  assign n_bgack  = !(state_q inside {OWN, RD, RD_END, WR_ADDR, WR, WR_END});
  assign bus_oe   = ~n_bgack;
  assign n_as_out = !(state_q inside {RD, WR_ADDR, WR});
  assign n_ds_out = !(state_q inside {RD, WR});
  assign rn_w_out = !(state_q inside {WR_ADDR, WR, WR_END});
  assign data_oe  = (state_q inside {WR_ADDR, WR, WR_END});
  assign data_out = {word_q, word_q};
  assign siz_out  = 2'b10;
  assign fc_out   = 3'b101;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = err_q;

  always_comb begin
    addr_out = '0;
    case (state_q)
      RD, RD_END:          addr_out = src_q;
      WR_ADDR, WR, WR_END: addr_out = dst_q;
      default:             addr_out = '0;
    endcase
  end

endmodule

// File: tb/tb_dma_bus_master.sv
// Bench for dma_bus_master: a bus responder/arbiter model plus a table of
// transfers and hand-written sequences for arbitration, timeout and reset.
`timescale 1ns/1ps
module tb_dma_bus_master;
  localparam int TIMEOUT   = 64;
  localparam int MAX_BURST = 16;

  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] count = '0;
  logic        busy, done, error, n_br, n_bgack, bus_oe;
  logic        n_bg = 1'b1;
  logic        n_as_in = 1'b1;
  logic        n_bgack_in = 1'b1;
  logic [31:0] addr_out, data_out;
  logic        n_as_out, n_ds_out, rn_w_out, data_oe;
  logic [1:0]  siz_out;
  logic [2:0]  fc_out;
  logic [31:0] data_in = '0;
  logic [1:0]  n_dsack = 2'b11;
  logic        n_berr = 1'b1;

  always #5 clock = ~clock;

  dma_bus_master #(.TIMEOUT(TIMEOUT), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .n_reset(n_reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .count(count), .busy(busy), .done(done), .error(error),
    .n_br(n_br), .n_bg(n_bg), .n_bgack(n_bgack), .n_as_in(n_as_in),
    .n_bgack_in(n_bgack_in), .bus_oe(bus_oe), .addr_out(addr_out),
    .n_as_out(n_as_out), .n_ds_out(n_ds_out), .rn_w_out(rn_w_out),
    .siz_out(siz_out), .fc_out(fc_out), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .n_dsack(n_dsack), .n_berr(n_berr)
  );

  int pass_cnt = 0;
  int check_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Responder configuration: 0=16-bit port, 1=32-bit port, 2=no ack, 3=byte port.
  int          mode = 0;
  int          wait_n = 0;
  int          berr_at = -1;
  logic [31:0] rd_fixed = '0;

  int          ncyc = 0, rd_idx = 0, ds_cnt = 0, done_cnt = 0, hi_run = 0, oe_bad = 0;
  logic        acked = 1'b0, prev_bgack = 1'b1;
  logic [31:0] rd_addr_q[$], wr_addr_q[$], wr_data_q[$];
  int          rd_cyc_q[$], gap_q[$];

  function automatic logic [31:0] rd_pattern(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, a[15:0] ^ 16'h5A5A};
  endfunction

  function automatic logic [15:0] exp_word(input int m, input logic [31:0] a,
                                           input logic [31:0] fixed);
    logic [31:0] d;
    d = (fixed != 0) ? fixed : rd_pattern(a);
    return (m == 1 && a[1]) ? d[15:0] : d[31:16];
  endfunction

  // Arbiter, bus responder and monitor, all acting on the falling edge.
  always @(negedge clock) begin
    ncyc++;
    n_bg = n_br;
    n_bgack_in = n_bgack;
    if (done === 1'b1) done_cnt++;
    if (prev_bgack && !n_bgack) gap_q.push_back(hi_run);
    hi_run = n_bgack ? hi_run + 1 : 0;
    prev_bgack = n_bgack;
    if (!n_ds_out) begin
      ds_cnt++;
      if (!acked && ds_cnt > wait_n) begin
        acked = 1'b1;
        if (rn_w_out) begin
          rd_idx++;
          data_in = (rd_fixed != 0) ? rd_fixed : rd_pattern(addr_out);
          if (mode < 2) begin
            rd_addr_q.push_back(addr_out);
            rd_cyc_q.push_back(ncyc);
          end
          if (rd_idx == berr_at) n_berr = 1'b0;
        end else if (mode < 2) begin
          wr_addr_q.push_back(addr_out);
          wr_data_q.push_back(data_out);
          if (!data_oe) oe_bad++;
        end
        case (mode)
          0:       n_dsack = 2'b01;
          1:       n_dsack = 2'b00;
          3:       n_dsack = 2'b10;
          default: n_dsack = 2'b11;
        endcase
      end
    end else begin
      ds_cnt  = 0;
      acked   = 1'b0;
      n_dsack = 2'b11;
      n_berr  = 1'b1;
    end
  end

  typedef struct {
    logic [15:0] cnt;
    logic [31:0] src;
    logic [31:0] dst;
    int          mode;
    int          berr;
    logic [31:0] fixed;
    int          exp_wr;
    logic        exp_err;
    int          exp_ten;
  } vec_t;

  task automatic pulse_start(input logic [15:0] c, input logic [31:0] s, input logic [31:0] d);
    @(negedge clock);
    src_addr = s;
    dst_addr = d;
    count    = c;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clock);
      if (done === 1'b1) got = 1;
    end
    check({name, " done seen"}, 32'(got), 32'd1);
    if (got != 0) begin
      check1({name, " n_bgack high at done"}, n_bgack, 1'b1);
      check1({name, " busy low at done"}, busy, 1'b0);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          rb, wb, db, gb, nb_wr, bad, gbad;
    logic [31:0] s0, d0;
    logic [15:0] w;
    mode     = v.mode;
    wait_n   = 0;
    rd_fixed = v.fixed;
    berr_at  = (v.berr > 0) ? rd_idx + v.berr : -1;
    rb = rd_addr_q.size();
    wb = wr_addr_q.size();
    db = done_cnt;
    gb = gap_q.size();
    pulse_start(v.cnt, v.src, v.dst);
    wait_done($sformatf("v%0d", idx), 3000);
    repeat (4) @(negedge clock);
    nb_wr = wr_addr_q.size() - wb;
    check($sformatf("v%0d writes", idx), 32'(nb_wr), 32'(v.exp_wr));
    check1($sformatf("v%0d error", idx), error, v.exp_err);
    check($sformatf("v%0d done pulses", idx), 32'(done_cnt - db), 32'd1);
    check($sformatf("v%0d tenures", idx), 32'(gap_q.size() - gb), 32'(v.exp_ten));
    s0 = v.src & 32'hFFFF_FFFE;
    d0 = v.dst & 32'hFFFF_FFFE;
    bad = 0;
    for (int i = 0; i < nb_wr; i++) begin
      w = exp_word(v.mode, s0 + 32'(2 * i), v.fixed);
      if (wr_addr_q[wb + i] !== d0 + 32'(2 * i)) bad++;
      if (wr_data_q[wb + i] !== {w, w}) bad++;
      if (rd_addr_q[rb + i] !== s0 + 32'(2 * i)) bad++;
    end
    check($sformatf("v%0d addr/data mismatches", idx), 32'(bad), 32'd0);
    if (v.exp_ten > 1) begin
      gbad = 0;
      for (int i = gb + 1; i < gap_q.size(); i++) if (gap_q[i] < 1) gbad++;
      check($sformatf("v%0d tenure gaps under 1 clock", idx), 32'(gbad), 32'd0);
    end
    if (nb_wr >= 2 && v.berr == 0)
      check($sformatf("v%0d clocks per word", idx), 32'(rd_cyc_q[rb + 1] - rd_cyc_q[rb]), 32'd5);
    if (idx == 1 && nb_wr >= 1)
      check($sformatf("v%0d data_out", idx), wr_data_q[wb], 32'h5555_5555);
  endtask

  initial begin
    vec_t vecs[8];
    int   got, n, db, wb;

    vecs[0] = '{16'd3,  32'h0100_0000, 32'h0200_0000, 0, 0, 32'h0,         3,  1'b0, 1};
    vecs[1] = '{16'd1,  32'h0100_0002, 32'h0300_0000, 1, 0, 32'hAAAA_5555, 1,  1'b0, 1};
    vecs[2] = '{16'd2,  32'h0100_0000, 32'h0300_0010, 1, 0, 32'h0,         2,  1'b0, 1};
    vecs[3] = '{16'd40, 32'h0110_0000, 32'h0210_0000, 0, 0, 32'h0,         40, 1'b0, 3};
    vecs[4] = '{16'd4,  32'h0120_0000, 32'h0220_0000, 0, 2, 32'h0,         1,  1'b1, 1};
    vecs[5] = '{16'd2,  32'h0100_0101, 32'h0200_0301, 0, 0, 32'h0,         2,  1'b0, 1};
    vecs[6] = '{16'd2,  32'h0130_0000, 32'h0230_0000, 3, 0, 32'h0,         0,  1'b1, 1};
    vecs[7] = '{16'd2,  32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0, 32'h0,         2,  1'b0, 1};

    #13;
    check1("reset n_br", n_br, 1'b1);
    check1("reset n_bgack", n_bgack, 1'b1);
    check1("reset bus_oe", bus_oe, 1'b0);
    check1("reset n_as_out", n_as_out, 1'b1);
    check1("reset n_ds_out", n_ds_out, 1'b1);
    check1("reset rn_w_out", rn_w_out, 1'b1);
    check1("reset data_oe", data_oe, 1'b0);
    check("reset addr_out", addr_out, 32'h0);
    check("reset data_out", data_out, 32'h0);
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset error", error, 1'b0);
    check("siz_out", 32'(siz_out), 32'd2);
    check("fc_out", 32'(fc_out), 32'd5);
    @(negedge clock);
    n_reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Grant arrives while the CPU still drives AS; a start while busy is ignored.
    mode = 0; rd_fixed = '0; berr_at = -1; wait_n = 0;
    wb = wr_addr_q.size();
    n_as_in = 1'b0;
    pulse_start(16'd1, 32'h0100_0100, 32'h0200_0100);
    check1("n_br low 1 clock after start", n_br, 1'b0);
    check1("busy after start", busy, 1'b1);
    pulse_start(16'd5, 32'h0150_0000, 32'h0250_0000);
    repeat (4) @(negedge clock);
    check1("no n_bgack while AS busy", n_bgack, 1'b1);
    n_as_in = 1'b1;
    got = 0;
    for (int i = 0; i < 4 && got == 0; i++) begin
      @(negedge clock);
      if (n_bgack == 1'b0) got = 1;
    end
    check("n_bgack after AS negates", 32'(got), 32'd1);
    check1("n_br high as n_bgack falls", n_br, 1'b1);
    wait_done("as_free", 200);
    check("as_free writes (second start ignored)", 32'(wr_addr_q.size() - wb), 32'd1);

    // No DSACK: strobes must negate exactly TIMEOUT clocks after AS.
    mode = 2;
    pulse_start(16'd1, 32'h0160_0000, 32'h0260_0000);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (n_as_out == 1'b0) got = 1;
      else @(negedge clock);
    end
    check("timeout AS asserted", 32'(got), 32'd1);
    n = 0;
    for (int i = 0; i < 400 && n_as_out == 1'b0; i++) begin
      @(negedge clock);
      n++;
    end
    check("timeout clocks AS low", 32'(n), 32'(TIMEOUT));
    wait_done("timeout", 20);
    check1("timeout error", error, 1'b1);

    // count = 0: done one clock after start, no bus activity.
    mode = 0;
    pulse_start(16'd0, 32'h0170_0000, 32'h0270_0000);
    check1("count0 done", done, 1'b1);
    check1("count0 busy", busy, 1'b0);
    check1("count0 n_br", n_br, 1'b1);
    @(negedge clock);
    check1("count0 done width", done, 1'b0);

    // Reset asserted mid write: bus released immediately, no done.
    wait_n = 3;
    pulse_start(16'd5, 32'h0180_0000, 32'h0280_0000);
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(negedge clock);
      if (!n_ds_out && !rn_w_out) got = 1;
    end
    check("reached WR", 32'(got), 32'd1);
    db = done_cnt;
    #2 n_reset = 1'b0;
    #1;
    check1("async reset n_bgack", n_bgack, 1'b1);
    check1("async reset n_as_out", n_as_out, 1'b1);
    check1("async reset n_ds_out", n_ds_out, 1'b1);
    check1("async reset bus_oe", bus_oe, 1'b0);
    check1("async reset data_oe", data_oe, 1'b0);
    check1("async reset busy", busy, 1'b0);
    repeat (3) @(negedge clock);
    n_reset = 1'b1;
    wait_n = 0;
    repeat (3) @(negedge clock);
    check("no done after reset", 32'(done_cnt - db), 32'd0);
    check1("idle after reset n_br", n_br, 1'b1);

    run_vec(8, vecs[0]);
    check("write strobes without data_oe", 32'(oe_bad), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
